johnson_phase_decoder: RTL and testbench
========================================

# johnson_phase_decoder

Downstream consumer of the 4-bit twisted-ring (Johnson) counter. Samples the counter's code each clock it is qualified and decodes it to an 8-phase one-hot word and a 3-bit phase index. Tracks sequence legality with a lock state machine and counts completed rotations. Its outputs drive the phase-gated logic that follows the counter, and it flags any illegal code or skipped step.

## Interface
- `CW`, 8: width of the rotation counter `cycle_cnt`; wraps modulo 2^CW.
- `LOCK_N`, 4: consecutive legal successor steps required to enter LOCKED; legal range 1..15.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; asserting low clears all state immediately.
- `code_in`  in  4  Johnson code from the upstream counter.
- `code_valid`  in  1  qualifies `code_in` for this cycle.
- `err_clr`  in  1  synchronous clear of `err_sticky`.
- `phase`  out  8  one-hot phase; bit k set for phase index k; 0 when no legal phase is held.
- `phase_idx`  out  3  index of the held phase.
- `phase_vld`  out  1  `phase` and `phase_idx` hold a legal code.
- `locked`  out  1  high in LOCKED.
- `step_err`  out  1  one-cycle pulse on a sequence error.
- `err_sticky`  out  1  set by `step_err`; cleared only by `err_clr` or reset.
- `cycle_cnt`  out  CW  completed rotations while LOCKED.
- `cycle_tick`  out  1  one-cycle pulse on each rotation completion.

## Operation
- Legal codes map to indices: 0000→0, 0001→1, 0011→2, 0111→3, 1111→4, 1110→5, 1100→6, 1000→7. The other 8 codes are illegal.
- The successor of index i is (i+1) mod 8.
- A sample is any cycle with `code_valid`=1. Non-sample cycles change no state; pulses return to 0.
- On a legal sample: `phase_vld`=1, `phase`=1<<idx, `phase_idx`=idx.
- On an illegal sample: `phase`=0, `phase_vld`=0, `phase_idx` holds its previous value.
- A sample is classified against the previously held index:
  - step: legal code and idx = successor.
  - stall: legal code and idx = previous.
  - bad: illegal code, or legal code that is neither step nor stall.
- State machine, with `ok_cnt` a 4-bit counter:
  - UNLOCKED (reset state): a legal sample moves to ACQUIRE with `ok_cnt`=0. An illegal sample stays in UNLOCKED. No `step_err` is raised in this state.
  - ACQUIRE:
    - step: `ok_cnt`+1. When it reaches LOCK_N, move to LOCKED.
    - stall: no change.
    - bad, legal code: restart ACQUIRE at the new index with `ok_cnt`=0. No error.
    - bad, illegal code: move to UNLOCKED. No error.
  - LOCKED:
    - step: normal operation.
    - stall: permitted, no change.
    - bad: `step_err`=1 for one cycle, `err_sticky`=1, move to UNLOCKED. The held phase updates per the legal/illegal rules above.
- Rotation: in LOCKED, a step from index 7 to index 0 increments `cycle_cnt` modulo 2^CW and pulses `cycle_tick`. The step that enters LOCKED never counts as a rotation.
- If `err_clr` and a new error occur in the same cycle, the set wins: `err_sticky`=1.
- `cycle_cnt` is not cleared on loss of lock. Only reset clears it.

## Timing
- All outputs are registered. Response appears on the cycle after the sampling edge: 1-cycle latency from `code_valid`/`code_in` to `phase`, `locked`, `step_err`, `cycle_tick`.
- `locked` rises on the same edge that registers the LOCK_N-th step.
- `step_err` and `cycle_tick` last exactly one cycle, even if the following cycle has no sample.
- Reset values: `phase`=0, `phase_idx`=0, `phase_vld`=0, `locked`=0, `step_err`=0, `err_sticky`=0, `cycle_cnt`=0, `cycle_tick`=0, state UNLOCKED, `ok_cnt`=0.
- Reset asserted mid-rotation forces the reset values asynchronously.
- After reset deasserts, the first legal sample enters ACQUIRE. No error is raised on that first sample.

## Test plan
- Reset, then `code_valid`=1 with the full Johnson sequence from 0000, LOCK_N=4:
  - `locked` rises after the 4th step, registered at code 1111 (index 4).
  - `phase` walks 0x01,0x02,…,0x80 with 1-cycle lag.
  - The first 0000 after 1000 in LOCKED gives `cycle_cnt`=1 and a 1-cycle `cycle_tick`.
- While LOCKED at index 3 (0111), drive 0101:
  - next cycle `step_err`=1, `err_sticky`=1, `locked`=0, `phase`=0, `phase_vld`=0.
- While LOCKED at index 2, drive 1111 (skip to index 4):
  - `step_err` pulse, `phase`=0x10, state UNLOCKED.
  - The following legal step starts ACQUIRE without a new error.
- Stall and gaps: repeat 0011 for 5 samples and insert `code_valid`=0 gaps mid-rotation.
  - No error, `locked` stays 1, `cycle_cnt` unchanged until 7→0.
- Wrap and error-clear: CW=2, run 5 rotations.
  - `cycle_cnt` sequence is 1,2,3,0,1.
  - Assert `err_clr` in the same cycle as an error sample: `err_sticky` stays 1.
  - `err_clr` alone clears it the next cycle.
- Async reset: drop `rst` low mid-cycle while LOCKED with `cycle_cnt`=3.
  - All outputs go to their reset values immediately, without waiting for a `clk` edge.

Source files
------------

// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
//   Samples a 4-bit Johnson (twisted-ring) code whenever it is qualified and
//   decodes it to an 8-phase one-hot word plus a 3-bit phase index. A lock
//   state machine tracks sequence legality. Completed rotations are counted
//   while locked, and any illegal code or skipped step seen while locked is
//   flagged.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous reset, active low
//   code_in     Johnson code from the upstream counter
//   code_valid  qualifies code_in this cycle (a "sample")
//   err_clr     synchronous clear of err_sticky (a new error wins)
//   phase       one-hot phase of the held legal code, 0 if none
//   phase_idx   index of the held phase (kept across illegal samples)
//   phase_vld   phase/phase_idx hold a legal code
//   locked      state machine is in LOCKED
//   step_err    one-cycle pulse on a sequence error while locked
//   err_sticky  latched step_err
//   cycle_cnt   completed rotations while locked, wraps modulo 2^CW
//   cycle_tick  one-cycle pulse on each rotation completion
module johnson_phase_decoder #(
  parameter int CW     = 8,
  parameter int LOCK_N = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    code_in,
  input  logic          code_valid,
  input  logic          err_clr,
  output logic [7:0]    phase,
  output logic [2:0]    phase_idx,
  output logic          phase_vld,
  output logic          locked,
  output logic          step_err,
  output logic          err_sticky,
  output logic [CW-1:0] cycle_cnt,
  output logic          cycle_tick
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_N_C = 4'(LOCK_N);

  state_e        state_q, state_d;
  logic [3:0]    ok_cnt_q, ok_cnt_d;
  logic [7:0]    phase_q, phase_d;
  logic [2:0]    phase_idx_q, phase_idx_d;
  logic          phase_vld_q, phase_vld_d;
  logic          step_err_q, step_err_d;
  logic          err_sticky_q, err_sticky_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic          cycle_tick_q, cycle_tick_d;

  // Code decode: the eight legal Johnson codes in ring order.
  logic       code_legal;
  logic [2:0] code_idx;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned, which would otherwise infer a latch.
    code_legal = 1'b1;
    code_idx   = 3'd0;
    unique case (code_in)
      4'b0000: code_idx = 3'd0;
      4'b0001: code_idx = 3'd1;
      4'b0011: code_idx = 3'd2;
      4'b0111: code_idx = 3'd3;
      4'b1111: code_idx = 3'd4;
      4'b1110: code_idx = 3'd5;
      4'b1100: code_idx = 3'd6;
      4'b1000: code_idx = 3'd7;
      default: code_legal = 1'b0;
    endcase
  end

  // Classification against the previously held index; the 3-bit add wraps
  // 7 -> 0, which is exactly the ring successor.
  logic [2:0] succ_idx;
  logic       is_step;
  logic       is_stall;
  logic [3:0] ok_cnt_inc;

  assign succ_idx   = phase_idx_q + 3'd1;
  assign is_step    = code_legal && (code_idx == succ_idx);
  assign is_stall   = code_legal && (code_idx == phase_idx_q);
  assign ok_cnt_inc = ok_cnt_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    ok_cnt_d     = ok_cnt_q;
    phase_d      = phase_q;
    phase_idx_d  = phase_idx_q;
    phase_vld_d  = phase_vld_q;
    cycle_cnt_d  = cycle_cnt_q;
    step_err_d   = 1'b0;
    cycle_tick_d = 1'b0;

    if (code_valid) begin
      // Held phase follows every sample; the index survives illegal codes.
      if (code_legal) begin
        phase_d     = 8'b1 << code_idx;
        phase_idx_d = code_idx;
        phase_vld_d = 1'b1;
      end else begin
        phase_d     = 8'b0;
        phase_vld_d = 1'b0;
      end

      unique case (state_q)
        ST_UNLOCKED: begin
          if (code_legal) begin
            state_d  = ST_ACQUIRE;
            ok_cnt_d = 4'd0;
          end
        end
        ST_ACQUIRE: begin
          if (is_step) begin
            ok_cnt_d = ok_cnt_inc;
            if (ok_cnt_inc == LOCK_N_C) state_d = ST_LOCKED;
          end else if (is_stall) begin
            // stall: hold
          end else if (code_legal) begin
            ok_cnt_d = 4'd0;  // restart acquisition at the new index
          end else begin
            state_d = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (is_step) begin
            // Only a 7 -> 0 step taken from LOCKED is a rotation, so the step
            // that enters LOCKED never counts.
            if (phase_idx_q == 3'd7) begin
              cycle_cnt_d  = cycle_cnt_q + CW'(1);
              cycle_tick_d = 1'b1;
            end
          end else if (!is_stall) begin
            step_err_d = 1'b1;
            state_d    = ST_UNLOCKED;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end

    // A new error takes priority over a simultaneous clear.
    err_sticky_d = step_err_d | (err_sticky_q & ~err_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_UNLOCKED;
      ok_cnt_q     <= 4'd0;
      phase_q      <= 8'b0;
      phase_idx_q  <= 3'd0;
      phase_vld_q  <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      cycle_cnt_q  <= '0;
      cycle_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ok_cnt_q     <= ok_cnt_d;
      phase_q      <= phase_d;
      phase_idx_q  <= phase_idx_d;
      phase_vld_q  <= phase_vld_d;
      step_err_q   <= step_err_d;
      err_sticky_q <= err_sticky_d;
      cycle_cnt_q  <= cycle_cnt_d;
      cycle_tick_q <= cycle_tick_d;
    end
  end

  assign phase      = phase_q;
  assign phase_idx  = phase_idx_q;
  assign phase_vld  = phase_vld_q;
  assign locked     = (state_q == ST_LOCKED);
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign cycle_tick = cycle_tick_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder with CW=2 (so the rotation counter
// wraps quickly) and LOCK_N=4. Every expected value is written by hand in the
// stimulus below; err_sticky and cycle_cnt expectations are held in exp_sticky
// and exp_cnt and updated explicitly where the stimulus changes them.
module tb_johnson_phase_decoder;

  localparam int CW     = 2;
  localparam int LOCK_N = 4;

  localparam logic [3:0] JC [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                    4'b1111, 4'b1110, 4'b1100, 4'b1000};

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    code_in;
  logic          code_valid;
  logic          err_clr;
  logic [7:0]    phase;
  logic [2:0]    phase_idx;
  logic          phase_vld;
  logic          locked;
  logic          step_err;
  logic          err_sticky;
  logic [CW-1:0] cycle_cnt;
  logic          cycle_tick;

  int            n_vec  = 0;
  int            n_miss = 0;
  logic          exp_sticky;
  logic [CW-1:0] exp_cnt;

  always #5 clk = ~clk;

  johnson_phase_decoder #(.CW(CW), .LOCK_N(LOCK_N)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .err_clr    (err_clr),
    .phase      (phase),
    .phase_idx  (phase_idx),
    .phase_vld  (phase_vld),
    .locked     (locked),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .cycle_cnt  (cycle_cnt),
    .cycle_tick (cycle_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compares every output against the expectation; phase follows from idx/vld.
  task automatic expect_out(input string tag, input int idx, input logic vld,
                            input logic lk, input logic err, input logic tick);
    logic [7:0] e_phase;
    e_phase = vld ? (8'b1 << idx) : 8'b0;
    check({tag, "/phase"},      32'(phase),      32'(e_phase));
    check({tag, "/phase_idx"},  32'(phase_idx),  32'(idx));
    check({tag, "/phase_vld"},  32'(phase_vld),  32'(vld));
    check({tag, "/locked"},     32'(locked),     32'(lk));
    check({tag, "/step_err"},   32'(step_err),   32'(err));
    check({tag, "/err_sticky"}, 32'(err_sticky), 32'(exp_sticky));
    check({tag, "/cycle_cnt"},  32'(cycle_cnt),  32'(exp_cnt));
    check({tag, "/cycle_tick"}, 32'(cycle_tick), 32'(tick));
  endtask

  // Inputs change 1 ns after a rising edge; outputs are read 1 ns after the
  // edge that registered them.
  task automatic drive(input logic [3:0] c, input logic v, input logic clr);
    code_in    = c;
    code_valid = v;
    err_clr    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input int idx, input logic lk,
                      input logic err, input logic tick);
    drive(JC[idx], 1'b1, 1'b0);
    expect_out(tag, idx, 1'b1, lk, err, tick);
  endtask

  // One locked rotation starting from index 0, ending with the 7 -> 0 step.
  task automatic rotate(input string tag, input logic [CW-1:0] cnt_after);
    for (int i = 1; i < 8; i++) step({tag, "_walk"}, i, 1'b1, 1'b0, 1'b0);
    exp_cnt = cnt_after;
    step({tag, "_wrap"}, 0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rst        = 1'b0;
    code_in    = 4'b0000;
    code_valid = 1'b0;
    err_clr    = 1'b0;
    exp_sticky = 1'b0;
    exp_cnt    = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Full sequence from 0000: locks on the 4th step (1111), no rotation yet.
    for (int i = 0; i < 8; i++) step("acq_walk", i, (i >= 4), 1'b0, 1'b0);
    exp_cnt = 2'd1;
    step("first_rot", 0, 1'b1, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b0);
    expect_out("tick_once", 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Stalls on 0011 with unqualified garbage in the gaps.
    step("st_1", 1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step("stall", 2, 1'b1, 1'b0, 1'b0);
      drive(4'b0101, 1'b0, 1'b0);
      expect_out("gap", 2, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    step("st_3", 3, 1'b1, 1'b0, 1'b0);
    step("st_4", 4, 1'b1, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0);
    expect_out("gap4", 4, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 5; i < 8; i++) step("st_walk", i, 1'b1, 1'b0, 1'b0);
    exp_cnt = 2'd2;
    step("st_rot", 0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) step("to_3", i, 1'b1, 1'b0, 1'b0);

    // Illegal code while locked at index 3: error, unlock, index held.
    drive(4'b0101, 1'b1, 1'b0);
    exp_sticky = 1'b1;
    expect_out("illegal", 3, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(4'b0101, 1'b0, 1'b0);
    expect_out("err_once", 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reacquire; a legal jump inside ACQUIRE restarts the step count silently.
    step("reacq_3", 3, 1'b0, 1'b0, 1'b0);
    step("reacq_4", 4, 1'b0, 1'b0, 1'b0);
    step("acq_jump", 1, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 5; i++) step("acq_restart", i, 1'b0, 1'b0, 1'b0);
    step("relock", 5, 1'b1, 1'b0, 1'b0);
    step("rl_6", 6, 1'b1, 1'b0, 1'b0);
    step("rl_7", 7, 1'b1, 1'b0, 1'b0);
    exp_cnt = 2'd3;
    step("rl_rot", 0, 1'b1, 1'b0, 1'b1);

    // err_clr on a clean stall clears the sticky flag.
    drive(JC[0], 1'b1, 1'b1);
    exp_sticky = 1'b0;
    expect_out("clr_stall", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("sk_1", 1, 1'b1, 1'b0, 1'b0);
    step("sk_2", 2, 1'b1, 1'b0, 1'b0);

    // Skip 2 -> 4 with err_clr in the same cycle: set wins.
    drive(JC[4], 1'b1, 1'b1);
    exp_sticky = 1'b1;
    expect_out("skip", 4, 1'b1, 1'b0, 1'b1, 1'b0);

    // Next legal sample starts ACQUIRE with no error; lock is entered on the
    // 7 -> 0 step, which must not count as a rotation.
    step("post_skip", 4, 1'b0, 1'b0, 1'b0);
    for (int i = 5; i < 8; i++) step("acq2", i, 1'b0, 1'b0, 1'b0);
    step("lock_on_wrap", 0, 1'b1, 1'b0, 1'b0);
    drive(JC[0], 1'b0, 1'b1);
    exp_sticky = 1'b0;
    expect_out("clr_alone", 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Counter wraps modulo 4: 3 -> 0 -> 1 -> 2 -> 3.
    rotate("rot_a", 2'd0);
    rotate("rot_b", 2'd1);
    rotate("rot_c", 2'd2);
    rotate("rot_d", 2'd3);

    // Asynchronous reset mid-cycle while locked with cycle_cnt = 3.
    step("pre_rst", 1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    exp_sticky = 1'b0;
    exp_cnt    = '0;
    expect_out("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("after_rst", 2, 1'b0, 1'b0, 1'b0);
    step("after_rst2", 3, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
